neurons_weight_loader: RTL
==========================

# neurons_weight_loader

Host-side sequencer that drives the write/stream port of the hidden-layer neuron block. It accepts 64-bit words over a valid/ready stream and unpacks the first 16 words into 64 16-bit weights, issued as `wen`/`weight_addr`/`weight_in` writes. It then forwards a programmed number of 64-bit images as `image`/`en` beats. It sits between the host register/FIFO path and `neurons_hidden`.

## Interface
- `NUM_WEIGHTS`, 64, weights written per load; must be a multiple of 4.
- `ADDR_W`, 6, weight address width; clog2(`NUM_WEIGHTS`).
- `WEIGHT_W`, 16, weight width.
- `IMG_W`, 64, stream word and image width; equals 4×`WEIGHT_W`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `cfg_start`  in  1  one-cycle start command; honoured only in IDLE.
- `num_images`  in  8  number of images to forward after the weight load; latched on an accepted `cfg_start`.
- `in_data`  in  `IMG_W`  stream data.
- `in_valid`  in  1  stream valid.
- `in_ready`  out  1  stream ready; a transfer occurs when `in_valid` and `in_ready` are both high at a rising edge.
- `wen`  out  1  weight write enable to the neuron block.
- `weight_addr`  out  `ADDR_W`  weight address.
- `weight_in`  out  `WEIGHT_W`  weight data.
- `en`  out  1  image-valid to the neuron block.
- `image`  out  `IMG_W`  image data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a job.

## Operation
- States: IDLE, WFETCH, WEMIT, GAP, IMG, DONE.
- **IDLE:** `in_ready`=0.
  - On `cfg_start`=1: latch `num_images`, clear the weight-word index and lane counters, go to WFETCH.
  - `cfg_start` in any other state is ignored.
- **WFETCH:** `in_ready`=1.
  - On a transfer: capture `in_data` into the word register, set lane=0, go to WEMIT.
- **WEMIT:** `in_ready`=0. Run 4 cycles, lane 0..3.
  - Each cycle: `wen`=1, `weight_addr`={word index, lane[1:0]}, `weight_in`=word[16·lane+15 : 16·lane]. Bits [15:0] go to the lowest address.
  - After lane 3: if the address was `NUM_WEIGHTS`-1, go to GAP; otherwise increment the word index and go to WFETCH.
- **GAP:** one cycle with `wen`=0, `en`=0, `weight_addr`=0, `weight_in`=0.
  - Then go to IMG, or to DONE if the latched count is 0.
- **IMG:** `in_ready`=1 while the remaining count > 0.
  - Each transfer: `image`<=`in_data`, `en`<=1, decrement the count.
  - Cycles without a transfer: `en`<=0 and `image` holds its value.
  - The transfer that brings the count to 0 moves the FSM to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE. The last image's `en` is high in this same cycle. `image` holds after the job.
- `wen` and `en` are never high in the same cycle.
- Count is 8 bits unsigned. `num_images`=255 forwards 255 images; no wrap-around.
- **Reset** (`rst`=0 at an edge), in any state, including mid-load:
  - state goes to IDLE and all counters clear;
  - all outputs go to 0: `in_ready`, `wen`, `weight_addr`, `weight_in`, `en`, `image`, `busy`, `done`.
  - A partially written weight set in the neuron block is not repaired; the host must restart.

## Timing
- All outputs are registered.
- Reset takes effect at the first rising edge with `rst`=0.
- `cfg_start` sampled at edge E:
  - `busy` and `in_ready` go high in the cycle after E (WFETCH).
- Weight-word transfer at edge T:
  - `wen`=1 for the 4 cycles after T, addresses 4k..4k+3;
  - `in_ready` returns high in the cycle after the lane-3 cycle.
- Throughput: 5 cycles per weight word, so 80 cycles minimum for 64 weights.
- `in_valid` low in WFETCH stalls the load indefinitely, with no `wen` pulses during the stall.
- GAP: exactly one idle cycle between the last `wen` and the first `in_ready` of IMG.
- Image transfer at edge T: `en`=1 and `image`=data in the cycle after T; one image per cycle sustained.
- Latency from `cfg_start` to `done`, with `in_valid` held high: 1 + 80 + 1 + N + 1 cycles for N ≥ 1.

## Test plan
- **Full load:**
  - Stimulus: `cfg_start` with `num_images`=2; words 0..15 = {16'h(4k+3), 16'h(4k+2), 16'h(4k+1), 16'h(4k)}, `in_valid` held high; then 2 images.
  - Required: 64 `wen` cycles with `weight_addr`=`weight_in`=0..63 in order; 1 GAP cycle; then the 2 images seen on `en`.
- **Backpressure:**
  - Stimulus: drop `in_valid` for 7 cycles after word 3.
  - Required: no `wen` during the stall; addresses resume at 16 with no duplicates or skips.
- **Zero images:**
  - Stimulus: `num_images`=0.
  - Required: `done` the cycle after GAP; `en` never asserted; `in_ready` low after the last weight word.
- **Image bubbles:**
  - Stimulus: `num_images`=3, images 64'h1830403030303c1c, 64'h201000e080c0f0f0, 64'h04040404143c0c04, each separated by 2 idle cycles.
  - Required: `en` pattern 1,0,0,1,0,0,1; `done` coincides with the third `en`; `image` holds its value through the bubbles.
- **Reset mid-load:**
  - Stimulus: assert `rst`=0 during WEMIT lane 2 of word 5.
  - Required: next cycle all outputs are 0 and the state is IDLE; a new `cfg_start` restarts writes at address 0.
- **Start while busy:**
  - Stimulus: pulse `cfg_start` with `num_images`=9 during IMG of a 2-image job.
  - Required: ignored; exactly 2 images are forwarded, then `done` and IDLE.

Source files
------------

// File: rtl/neurons_weight_loader.sv
// Host-side sequencer for neurons_hidden: unpacks the first NUM_WEIGHTS/4 stream
// words into weight writes, then forwards a latched number of images.
module neurons_weight_loader #(
  parameter int NUM_WEIGHTS = 64,
  parameter int ADDR_W      = 6,
  parameter int WEIGHT_W    = 16,
  parameter int IMG_W       = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [7:0]          num_images,
  input  logic [IMG_W-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                wen,
  output logic [ADDR_W-1:0]   weight_addr,
  output logic [WEIGHT_W-1:0] weight_in,
  output logic                en,
  output logic [IMG_W-1:0]    image,
  output logic                busy,
  output logic                done
);

  localparam int WIDX_W = ADDR_W - 2;

  typedef enum logic [2:0] {IDLE, WFETCH, WEMIT, GAP, IMG, DONE} state_t;

  state_t              state;
  logic [IMG_W-1:0]    word;
  logic [WIDX_W-1:0]   widx;
  logic [1:0]          lane;
  logic [7:0]          cnt;
  logic [1:0]          lane_nxt;
  logic [WEIGHT_W-1:0] lane_word;

  assign lane_nxt  = lane + 2'd1;
  assign lane_word = word[int'(lane_nxt) * WEIGHT_W +: WEIGHT_W];

  // Outputs are loaded on the transition into the cycle they describe, so every
  // output is a plain register with no decode after the flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      word        <= '0;
      widx        <= '0;
      lane        <= '0;
      cnt         <= '0;
      in_ready    <= 1'b0;
      wen         <= 1'b0;
      weight_addr <= '0;
      weight_in   <= '0;
      en          <= 1'b0;
      image       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            cnt      <= num_images;
            widx     <= '0;
            lane     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= WFETCH;
          end
        end
        WFETCH: begin
          if (in_valid && in_ready) begin
            word        <= in_data;
            lane        <= '0;
            in_ready    <= 1'b0;
            wen         <= 1'b1;
            weight_addr <= {widx, 2'b00};
            weight_in   <= in_data[WEIGHT_W-1:0];
            state       <= WEMIT;
          end
        end
        WEMIT: begin
          if (lane != 2'd3) begin
            lane        <= lane_nxt;
            weight_addr <= {widx, lane_nxt};
            weight_in   <= lane_word;
          end else begin
            wen         <= 1'b0;
            weight_addr <= '0;
            weight_in   <= '0;
            if ({widx, lane} == ADDR_W'(NUM_WEIGHTS - 1)) begin
              state <= GAP;
            end else begin
              widx     <= widx + 1'b1;
              in_ready <= 1'b1;
              state    <= WFETCH;
            end
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= IMG;
          end
        end
        IMG: begin
          if (in_valid && in_ready) begin
            image <= in_data;
            en    <= 1'b1;
            cnt   <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end else begin
            en <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
